// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and ALU command encodings for the ID/EX stage
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef logic [2:0] alu_cmd_t;

    localparam alu_cmd_t ALU_ADD = 3'b000;
    localparam alu_cmd_t ALU_SUB = 3'b001;
    localparam alu_cmd_t ALU_SLL = 3'b010;
    localparam alu_cmd_t ALU_SGT = 3'b011;
    localparam alu_cmd_t ALU_SRL = 3'b100;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass select from EX/MEM, MEM/WB or the stage register
module fwd_mux #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_wb_en_i,
    input  logic              exmem_is_load_i,
    input  logic [DATA_W-1:0] exmem_res_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_wb_en_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] fwd_val_o
);

    // Youngest producer wins; a load in EX/MEM has no data yet, and r0 is hardwired to zero
    always_comb begin
        fwd_val_o = reg_val_i;
        if (rs_i == '0) begin
            fwd_val_o = '0;
        end else if (exmem_wb_en_i && !exmem_is_load_i && (exmem_rd_i == rs_i)) begin
            fwd_val_o = exmem_res_i;
        end else if (memwb_wb_en_i && (memwb_rd_i == rs_i)) begin
            fwd_val_o = memwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bypassing, load-use bubble, hold and flush
module id_ex_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_op1,
    input  logic [DATA_W-1:0] id_op2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [2:0]        id_cmd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wb_en,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_wb_en,
    input  logic              exmem_is_load,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_wb_en,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              hold,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [2:0]        alu_cmd,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic              ex_is_load,
    output logic [REG_AW-1:0] ex_rd,
    output logic              id_stall
);

    import mips_pkg::*;

    logic              valid_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] imm_q;
    logic              use_imm_q;
    logic [2:0]        cmd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              wb_en_q;
    logic              is_load_q;

    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic              load_use;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_op1 (
        .rs_i           (rs1_q),
        .reg_val_i      (op1_q),
        .exmem_rd_i     (exmem_rd),
        .exmem_wb_en_i  (exmem_wb_en),
        .exmem_is_load_i(exmem_is_load),
        .exmem_res_i    (exmem_res),
        .memwb_rd_i     (memwb_rd),
        .memwb_wb_en_i  (memwb_wb_en),
        .memwb_data_i   (memwb_data),
        .fwd_val_o      (fwd1)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_op2 (
        .rs_i           (rs2_q),
        .reg_val_i      (op2_q),
        .exmem_rd_i     (exmem_rd),
        .exmem_wb_en_i  (exmem_wb_en),
        .exmem_is_load_i(exmem_is_load),
        .exmem_res_i    (exmem_res),
        .memwb_rd_i     (memwb_rd),
        .memwb_wb_en_i  (memwb_wb_en),
        .memwb_data_i   (memwb_data),
        .fwd_val_o      (fwd2)
    );

    // A load in EX cannot feed the decode instruction; an immediate replaces rs2 so it never conflicts
    always_comb begin
        load_use = valid_q && is_load_q && (rd_q != '0) && id_valid &&
                   ((rd_q == id_rs1) || ((rd_q == id_rs2) && !id_use_imm));
    end

    assign id_stall   = hold | load_use;
    assign alu_op1    = fwd1;
    assign alu_op2    = use_imm_q ? imm_q : fwd2;
    assign alu_cmd    = valid_q ? cmd_q : ALU_ADD;
    assign ex_valid   = valid_q;
    assign ex_wb_en   = wb_en_q;
    assign ex_is_load = is_load_q;
    assign ex_rd      = rd_q;

    // Stage register: flush beats hold beats load-use bubble beats normal capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            cmd_q     <= ALU_ADD;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            is_load_q <= 1'b0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            cmd_q     <= ALU_ADD;
        end else if (hold) begin
            // Re-latch bypassed operands so a producer retiring mid-hold is not lost
            op1_q     <= fwd1;
            op2_q     <= fwd2;
        end else if (load_use) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            valid_q   <= id_valid;
            op1_q     <= id_op1;
            op2_q     <= id_op2;
            imm_q     <= id_imm;
            use_imm_q <= id_use_imm;
            cmd_q     <= id_cmd;
            rs1_q     <= id_rs1;
            rs2_q     <= id_rs2;
            rd_q      <= id_rd;
            wb_en_q   <= id_wb_en & id_valid;
            is_load_q <= id_is_load & id_valid;
        end
    end

endmodule
